// File: rtl/multicycle_control_unit.sv
// Moore control FSM for a multicycle MIPS-subset datapath with memory wait states
// and a retired-instruction counter. Define ILLEGAL_TRAP_EN to trap on illegal opcodes.
module multicycle_control_unit #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic                zero,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [1:0]          pc_source,
  output logic [CNT_W-1:0]    instr_count,
  output logic                trap
);

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);

  typedef enum logic [3:0] {
    sFetch, sDecode, sExecR, sWbR, sExecI, sWbI, sMemAddr,
    sMemRead, sMemWb, sMemWrite, sBranch, sJump
`ifdef ILLEGAL_TRAP_EN
    , sTrap
`endif
  } state_t;

  typedef struct packed {
    logic               pcWrite;
    logic               pcWriteCond;
    logic               iOrD;
    logic               memRead;
    logic               memWrite;
    logic               irWrite;
    logic               memToReg;
    logic               regDst;
    logic               regWrite;
    logic               aluSrcA;
    logic [1:0]         aluSrcB;
    logic [ALUOP_W-1:0] aluOp;
    logic [1:0]         pcSource;
`ifdef ILLEGAL_TRAP_EN
    logic               trap;
`endif
  } ctrl_t;

  state_t           state, stateNext;
  ctrl_t            ctrlQ, ctrlOut;
  logic             retire, stateKnown, fetchHold;
  logic [CNT_W-1:0] instrCount;
  logic             unusedZero;

  // zero only qualifies pc_write_cond in the datapath
  assign unusedZero = zero;

  function automatic ctrl_t ctrlOf(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      sFetch:    begin c.memRead = 1'b1; c.irWrite = 1'b1; c.pcWrite = 1'b1; c.aluSrcB = 2'b01; end
      sDecode:   c.aluSrcB = 2'b11;
      sExecR:    begin c.aluSrcA = 1'b1; c.aluOp = ALUOP_W'(2'b10); end
      sWbR:      begin c.regDst = 1'b1; c.regWrite = 1'b1; end
      sExecI:    begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
      sWbI:      c.regWrite = 1'b1;
      sMemAddr:  begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
      sMemRead:  begin c.memRead = 1'b1; c.iOrD = 1'b1; end
      sMemWb:    begin c.regWrite = 1'b1; c.memToReg = 1'b1; end
      sMemWrite: begin c.memWrite = 1'b1; c.iOrD = 1'b1; end
      sBranch:   begin
        c.aluSrcA = 1'b1; c.aluOp = ALUOP_W'(2'b01);
        c.pcSource = 2'b01; c.pcWriteCond = 1'b1;
      end
      sJump:     begin c.pcSource = 2'b10; c.pcWrite = 1'b1; end
`ifdef ILLEGAL_TRAP_EN
      sTrap:     c.trap = 1'b1;
`endif
      default:   c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    stateNext  = state;
    retire     = 1'b0;
    stateKnown = 1'b1;
    case (state)
      sFetch:    if (mem_ready) stateNext = sDecode;
      sDecode: begin
        case (opcode)
          OP_R:         stateNext = sExecR;
          OP_ADDI:      stateNext = sExecI;
          OP_LW, OP_SW: stateNext = sMemAddr;
          OP_BEQ:       stateNext = sBranch;
          OP_J:         stateNext = sJump;
`ifdef ILLEGAL_TRAP_EN
          default:      stateNext = sTrap;
`else
          default:      stateNext = sFetch;
`endif
        endcase
      end
      sExecR:    stateNext = sWbR;
      sExecI:    stateNext = sWbI;
      sMemAddr:  stateNext = (opcode == OP_LW) ? sMemRead : sMemWrite;
      sMemRead:  if (mem_ready) stateNext = sMemWb;
      sMemWrite: if (mem_ready) begin stateNext = sFetch; retire = 1'b1; end
      sWbR, sWbI, sMemWb, sBranch, sJump: begin
        stateNext = sFetch;
        retire    = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      sTrap:     stateNext = sTrap;
`endif
      default: begin
        stateNext  = sFetch;
        stateKnown = 1'b0;
      end
    endcase
  end

  // Control word is registered from the next state so outputs depend on state only
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= sFetch;
      ctrlQ      <= ctrlOf(sFetch);
      instrCount <= '0;
    end else begin
      state <= stateNext;
      ctrlQ <= ctrlOf(stateNext);
      if (retire) instrCount <= instrCount + CNT_W'(1);
    end
  end

  assign ctrlOut   = (rst_n && stateKnown) ? ctrlQ : '0;
  // A fetch that has not completed must not latch IR or advance the PC
  assign fetchHold = (state == sFetch) && !mem_ready;

  assign pc_write      = ctrlOut.pcWrite & ~fetchHold;
  assign ir_write      = ctrlOut.irWrite & ~fetchHold;
  assign pc_write_cond = ctrlOut.pcWriteCond;
  assign i_or_d        = ctrlOut.iOrD;
  assign mem_read      = ctrlOut.memRead;
  assign mem_write     = ctrlOut.memWrite;
  assign mem_to_reg    = ctrlOut.memToReg;
  assign reg_dst       = ctrlOut.regDst;
  assign reg_write     = ctrlOut.regWrite;
  assign alu_src_a     = ctrlOut.aluSrcA;
  assign alu_src_b     = ctrlOut.aluSrcB;
  assign alu_op        = ctrlOut.aluOp;
  assign pc_source     = ctrlOut.pcSource;
  assign instr_count   = instrCount;
`ifdef ILLEGAL_TRAP_EN
  assign trap          = ctrlOut.trap;
`else
  assign trap          = 1'b0;
`endif

endmodule
